// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the seven-segment scan driver.
// Hex-to-segment table (active low, {g..a}), blank codes and digit count.
package seg7_pkg;

    localparam int DIGITS = 8;

    localparam logic [7:0] AN_OFF  = 8'hFF;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Entry n holds the {g,f,e,d,c,b,a} pattern for hex digit n.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46,
        7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19,
        7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_scan_drv_hex2seg7.sv
// hex2seg7: 4-bit nibble to active-low {g..a} segment pattern.
// Purely combinational table lookup.
module hex2seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern.
    always_comb begin
        seg = HEX_SEG[nibble];
    end

endmodule

// File: rtl/seg7_scan_drv.sv
// seg7_scan_drv: 8-digit common-anode seven-segment scan driver.
// Optional macro SEG7_GHOST_GUARD_EN blanks AN for GUARD_CYC cycles per slot.
module seg7_scan_drv
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV_W  = 16,
    parameter int BLINK_DIV_W = 25,
    parameter int GUARD_CYC   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EN,
    input  logic [31:0] Disp_num,
    input  logic [7:0]  point_in,
    input  logic [7:0]  blink_in,
    output logic [7:0]  AN,
    output logic [7:0]  SEGMENT,
    output logic        frame_tick
);

    logic [SCAN_DIV_W-1:0]  presc;
    logic [2:0]             idx;
    logic [BLINK_DIV_W-1:0] blink_cnt;
    logic [31:0]            shadow_data;
    logic [7:0]             shadow_pt;
    logic [7:0]             shadow_bl;

    logic       tick;
    logic       frame_edge;
    logic [3:0] cur_nib;
    logic [6:0] cur_seg;
    logic       blank;
    logic [7:0] an_nxt;
    logic [7:0] seg_nxt;

    if (GUARD_CYC >= (1 << SCAN_DIV_W)) begin : g_guard_chk
        $error("GUARD_CYC must be smaller than one digit slot");
    end

    assign tick       = &presc;
    assign frame_edge = tick & (idx == 3'd7);
    assign cur_nib    = shadow_data[{idx, 2'b00} +: 4];

    hex2seg7 u_hex2seg7 (
        .nibble (cur_nib),
        .seg    (cur_seg)
    );

    // Free-running scan prescaler, digit index and blink counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc     <= '0;
            idx       <= '0;
            blink_cnt <= '0;
        end else begin
            presc     <= presc + 1'b1;
            blink_cnt <= blink_cnt + 1'b1;
            if (tick) begin
                idx <= idx + 3'd1;
            end
        end
    end

    // Shadow capture only at frame boundaries so a frame never tears.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_data <= '0;
            shadow_pt   <= '0;
            shadow_bl   <= '0;
        end else if (frame_edge && EN) begin
            shadow_data <= Disp_num;
            shadow_pt   <= point_in;
            shadow_bl   <= blink_in;
        end
    end

    // Next anode/segment values for the digit currently indexed.
    always_comb begin
        blank   = shadow_bl[idx] & blink_cnt[BLINK_DIV_W-1];
        an_nxt  = ~(8'b1 << idx);
        seg_nxt = {~shadow_pt[idx], cur_seg};
        if (blank) begin
            an_nxt  = AN_OFF;
            seg_nxt = SEG_OFF;
        end
`ifdef SEG7_GHOST_GUARD_EN
        if (presc < SCAN_DIV_W'(GUARD_CYC)) begin
            an_nxt = AN_OFF;
        end
`endif
    end

    // Registered outputs and frame-boundary pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            AN         <= AN_OFF;
            SEGMENT    <= SEG_OFF;
            frame_tick <= 1'b0;
        end else begin
            AN         <= an_nxt;
            SEGMENT    <= seg_nxt;
            frame_tick <= frame_edge;
        end
    end

endmodule

// File: tb/tb_seg7_scan_drv.sv
// tb_seg7_scan_drv: self-checking bench for seg7_scan_drv.
// Cycle-indexed reference model plus directed literal checks.
module tb_seg7_scan_drv;

    localparam int SW = 2;
    localparam int BW = 6;
    localparam int GC = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        EN = 1'b0;
    logic [31:0] Disp_num = '0;
    logic [7:0]  point_in = '0;
    logic [7:0]  blink_in = '0;
    logic [7:0]  AN;
    logic [7:0]  SEGMENT;
    logic        frame_tick;

    int total = 0;
    int bad = 0;

    seg7_scan_drv #(
        .SCAN_DIV_W  (SW),
        .BLINK_DIV_W (BW),
        .GUARD_CYC   (GC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .EN         (EN),
        .Disp_num   (Disp_num),
        .point_in   (point_in),
        .blink_in   (blink_in),
        .AN         (AN),
        .SEGMENT    (SEGMENT),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Seven-segment codes, dp bit set (off).
    function automatic logic [7:0] hexcode(input logic [3:0] n);
        logic [7:0] r;
        case (n)
            4'h0: r = 8'hC0;
            4'h1: r = 8'hF9;
            4'h2: r = 8'hA4;
            4'h3: r = 8'hB0;
            4'h4: r = 8'h99;
            4'h5: r = 8'h92;
            4'h6: r = 8'h82;
            4'h7: r = 8'hF8;
            4'h8: r = 8'h80;
            4'h9: r = 8'h90;
            4'hA: r = 8'h88;
            4'hB: r = 8'h83;
            4'hC: r = 8'hC6;
            4'hD: r = 8'hA1;
            4'hE: r = 8'h86;
            default: r = 8'h8E;
        endcase
        return r;
    endfunction

    // Output pair expected after an edge with c edges elapsed before it.
    function automatic logic [15:0] outs(input int c, input logic [31:0] d,
                                         input logic [7:0] pt,
                                         input logic [7:0] bl);
        int         slot_len;
        int         p;
        int         i;
        logic       bph;
        logic [3:0] nib;
        logic [7:0] hc;
        logic [7:0] an;
        logic [7:0] sg;
        slot_len = 1 << SW;
        p   = c % slot_len;
        i   = (c / slot_len) % 8;
        bph = (c % (1 << BW)) >= (1 << (BW - 1));
        nib = 4'((d >> (4 * i)) & 32'hF);
        hc  = hexcode(nib);
        an  = ~(8'h01 << i);
        sg  = {~pt[i], hc[6:0]};
        if (bl[i] && bph) begin
            an = 8'hFF;
            sg = 8'hFF;
        end
`ifdef SEG7_GHOST_GUARD_EN
        if (p < GC) an = 8'hFF;
`endif
        return {an, sg};
    endfunction

    int          cyc;
    logic [31:0] m_d;
    logic [7:0]  m_p;
    logic [7:0]  m_b;
    logic [7:0]  m_an;
    logic [7:0]  m_seg;
    logic        m_ft;

    // Reference model: edge count since reset drives the whole schedule.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc   <= 0;
            m_d   <= '0;
            m_p   <= '0;
            m_b   <= '0;
            m_an  <= 8'hFF;
            m_seg <= 8'hFF;
            m_ft  <= 1'b0;
        end else begin
            {m_an, m_seg} <= outs(cyc, m_d, m_p, m_b);
            m_ft <= (cyc % (8 << SW)) == ((8 << SW) - 1);
            if (((cyc % (8 << SW)) == ((8 << SW) - 1)) && EN) begin
                m_d <= Disp_num;
                m_p <= point_in;
                m_b <= blink_in;
            end
            cyc <= cyc + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst) begin
            check("mdl_an", {24'h0, AN}, {24'h0, m_an});
            check("mdl_seg", {24'h0, SEGMENT}, {24'h0, m_seg});
            check("mdl_ft", {31'h0, frame_tick}, {31'h0, m_ft});
        end
    end

    task automatic wait_ft();
        bit seen;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                seen = 1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL wait_ft: got=no_tick want=tick t=%0t", $time);
        end
    endtask

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [7:0] a1;
    logic [7:0] s1;
    logic [7:0] a2;
    logic [7:0] s2;
    logic [7:0] an_lit [8];

    initial begin
        an_lit = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

        skip(3);
        #1;
        check("rst_an", {24'h0, AN}, 32'hFF);
        check("rst_seg", {24'h0, SEGMENT}, 32'hFF);
        check("rst_ft", {31'h0, frame_tick}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        skip(2);
        for (int d = 0; d < 8; d++) begin
            check("scan_an", {24'h0, AN}, {24'h0, an_lit[d]});
            check("scan_seg", {24'h0, SEGMENT}, 32'hC0);
            if (d < 7) skip(4);
        end

        EN       = 1'b1;
        Disp_num = 32'h89ABCDEF;
        point_in = 8'h01;
        wait_ft();
        skip(2);
        check("f1_d0_an", {24'h0, AN}, 32'hFE);
        check("f1_d0_seg", {24'h0, SEGMENT}, 32'h0E);
        skip(4);
        check("f1_d1_seg", {24'h0, SEGMENT}, 32'h86);
        Disp_num = 32'h12345678;
        skip(24);
        check("f1_d7_an", {24'h0, AN}, 32'h7F);
        check("f1_d7_seg", {24'h0, SEGMENT}, 32'h80);

        wait_ft();
        skip(2);
        check("f2_d0_seg", {24'h0, SEGMENT}, 32'h00);
        blink_in = 8'h04;

        wait_ft();
        skip(10);
        a1 = AN;
        s1 = SEGMENT;
        skip(4);
        check("bl_d3_an", {24'h0, AN}, 32'hF7);
        check("bl_d3_seg", {24'h0, SEGMENT}, 32'h92);
        wait_ft();
        skip(10);
        a2 = AN;
        s2 = SEGMENT;
        total++;
        if (!(({a1, s1, a2, s2} == 32'hFFFF_FB82) ||
              ({a1, s1, a2, s2} == 32'hFB82_FFFF))) begin
            bad++;
            $display("FAIL blink_pair: got=%h want=FFFFFB82/FB82FFFF",
                     {a1, s1, a2, s2});
        end

        skip(1);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_an", {24'h0, AN}, 32'hFF);
        check("mid_rst_seg", {24'h0, SEGMENT}, 32'hFF);
        EN = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        skip(2);
        check("post_rst_an", {24'h0, AN}, 32'hFE);
        check("post_rst_seg", {24'h0, SEGMENT}, 32'hC0);
        skip(16);
        check("post_rst_d4", {24'h0, AN}, 32'hEF);
        check("post_rst_d4s", {24'h0, SEGMENT}, 32'hC0);

        Disp_num = 32'h0F1E2D3C;
        point_in = 8'hA5;
        blink_in = 8'h81;
        EN       = 1'b1;
        skip(140);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seg7_scan_drv.md
Name: seg7_scan_drv

Overview:
- Downstream consumer of the 8-channel display-data multiplexer: takes the selected 32-bit display word, 8-bit point mask and 8-bit blink mask.
- Time-multiplexes eight hex digits onto a common-anode 8-digit seven-segment display.
- Captures inputs only at frame boundaries, so a frame never tears.
- Generates scan, blink and (optionally) anti-ghosting timing.

Parameters:
- SCAN_DIV_W, 16, scan prescaler width; one digit slot lasts 2^SCAN_DIV_W clk cycles.
- BLINK_DIV_W, 25, blink counter width; blink phase = counter MSB.
- GUARD_CYC, 4, blanking cycles at the start of each digit slot (used only with the optional feature); must be < 2^SCAN_DIV_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- EN  in  1  capture enable, sampled at frame boundary.
- Disp_num  in  32  display word; digit i = Disp_num[4i+3:4i].
- point_in  in  8  decimal point per digit, 1 = lit.
- blink_in  in  8  blink per digit, 1 = blink.
- AN  out  8  digit anodes, active low.
- SEGMENT  out  8  {dp,g,f,e,d,c,b,a}, active low.
- frame_tick  out  1  one-cycle pulse on a frame-boundary capture edge.

Behaviour:
- Reset (rst=0, async):
  - prescaler = 0, idx = 0, blink counter = 0.
  - Shadow data / point / blink = 0.
  - AN = 8'hFF, SEGMENT = 8'hFF, frame_tick = 0.
- Prescaler: free-running SCAN_DIV_W-bit up-counter. tick = (prescaler == all-ones); wraps to 0.
- Digit index idx (3-bit): increments on the edge where tick=1; 7 wraps to 0.
- Frame boundary = edge where tick=1 and idx==7. On that edge:
  - If EN=1: shadow_data <= Disp_num, shadow_pt <= point_in, shadow_bl <= blink_in.
  - If EN=0: shadows hold their values.
  - frame_tick = 1 for the cycle after the edge, independent of EN.
- Inputs are ignored at all other times; mid-frame changes have no effect.
- Blink counter: free-running BLINK_DIV_W-bit counter, wraps. blink_phase = MSB.
- Output stage (registered; outputs reflect idx and shadows one clk later):
  - blank = shadow_bl[idx] & blink_phase.
  - AN = blank ? 8'hFF : ~(8'b1 << idx).
  - SEGMENT[6:0] = hex decode of shadow nibble idx.
  - SEGMENT[7] = ~shadow_pt[idx].
  - When blank=1, SEGMENT = 8'hFF.
- Hex decode, {dp=1,g..a}:
  - 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8
  - 8:80 9:90 A:88 B:83 C:C6 D:A1 E:86 F:8E
- Boundaries:
  - At the frame-boundary edge, idx goes 0 and the new shadows load on the same edge, so digit 0 of the new frame already shows new data.
  - Simultaneous blink-phase change and digit change: both take effect on the same output update.
  - Reset asserted mid-frame: outputs go to FF immediately (async).
  - After reset release: display shows "00000000", DPs off, until the first capture with EN=1.
  - At most one AN bit is low at any time.

Optional Feature:
- Macro: SEG7_GHOST_GUARD_EN.
- Defined: AN = 8'hFF while prescaler < GUARD_CYC within each digit slot (first GUARD_CYC cycles after idx changes, as seen at the output). SEGMENT still updates normally.
- Undefined: no guard; AN switches directly between digits.

Decomposition:
- Package seg7_pkg: 16-entry hex-to-segment constant table, AN_OFF = 8'hFF, SEG_OFF = 8'hFF, DIGITS = 8.
- One combinational sub-module, hex2seg7 (4-bit nibble -> 7-bit active-low segments).
- Counters, shadows, blink and output registers stay in the top.

Test Plan (SCAN_DIV_W=2, BLINK_DIV_W=6, GUARD_CYC=1):
- Reset hold, then release with EN=0 -> AN=FF during reset; after release AN cycles FE,FD,...,7F every 4 clks with SEGMENT=C0.
- EN=1, Disp_num=32'h89ABCDEF, point_in=8'h01 -> after first frame_tick: digit0 SEGMENT=0E (F with dp lit), digit1=86, digit7=80.
- Change Disp_num to 32'h12345678 mid-frame -> current frame unchanged; new value appears only after the next frame_tick.
- blink_in=8'h04 -> while blink MSB=1, slot 2 shows AN=FF/SEGMENT=FF; other digits unaffected; while MSB=0, slot 2 is normal.
- Assert rst for 1 clk mid-slot -> AN/SEGMENT=FF asynchronously; idx restarts at 0 and shadows clear to 0.
- With SEG7_GHOST_GUARD_EN -> the first cycle of every slot has AN=FF; without the macro there is no such cycle.
